pcpi_issuer: RTL and testbench

//  Initiator (CPU-side) end of the PCPI coprocessor interface. Accepts one

---
 rtl/pcpi_issuer_if.sv | 60 ++++++
 rtl/pcpi_issuer.sv | 158 +++++++++++++++
 tb/tb_pcpi_issuer.sv | 265 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/pcpi_issuer_if.sv
// Bundles the signals between the PCPI issuer and its surroundings. The bundle
// covers the command port, the PCPI bus to the coprocessor, the response port
// and the protocol-error flag.
//
// Handshake semantics (cmd_* and rsp_*):
//   A transfer happens on a rising edge where valid && ready are both high.
//   The producer keeps valid and its payload stable until that edge. The
//   consumer may raise or drop ready at any time. valid never depends on ready.
//
// modport master : the issuer side (drives cmd_ready, pcpi_*, rsp_*, proto_err)
// modport slave  : the environment side (command source, coprocessor, response sink)
interface pcpi_issuer_if #(
  parameter int XLEN  = 32,
  parameter int CYC_W = 16
);
  // command port
  logic             cmd_valid;
  logic             cmd_ready;
  logic [XLEN-1:0]  cmd_insn;
  logic [XLEN-1:0]  cmd_rs1;
  logic [XLEN-1:0]  cmd_rs2;
  // PCPI bus
  logic             pcpi_valid;
  logic [XLEN-1:0]  pcpi_insn;
  logic [XLEN-1:0]  pcpi_rs1;
  logic [XLEN-1:0]  pcpi_rs2;
  logic             pcpi_wr;
  logic [XLEN-1:0]  pcpi_rd;
  logic             pcpi_wait;
  logic             pcpi_ready;
  // response port
  logic             rsp_valid;
  logic             rsp_ready;
  logic [XLEN-1:0]  rsp_rd;
  logic             rsp_wr;
  logic             rsp_timeout;
  logic [CYC_W-1:0] rsp_cycles;
  // status
  logic             proto_err;

  modport master (
    input  cmd_valid, cmd_insn, cmd_rs1, cmd_rs2,
    output cmd_ready,
    output pcpi_valid, pcpi_insn, pcpi_rs1, pcpi_rs2,
    input  pcpi_wr, pcpi_rd, pcpi_wait, pcpi_ready,
    output rsp_valid, rsp_rd, rsp_wr, rsp_timeout, rsp_cycles,
    input  rsp_ready,
    output proto_err
  );

  modport slave (
    output cmd_valid, cmd_insn, cmd_rs1, cmd_rs2,
    input  cmd_ready,
    input  pcpi_valid, pcpi_insn, pcpi_rs1, pcpi_rs2,
    output pcpi_wr, pcpi_rd, pcpi_wait, pcpi_ready,
    input  rsp_valid, rsp_rd, rsp_wr, rsp_timeout, rsp_cycles,
    output rsp_ready,
    input  proto_err
  );
endinterface

// File: rtl/pcpi_issuer.sv
// PCPI initiator. It accepts one instruction plus two operands on the command
// port and presents them to a PCPI coprocessor. It then waits for pcpi_ready,
// or aborts after TIMEOUT consecutive cycles in which neither pcpi_wait nor
// pcpi_ready is seen. The result, the timeout flag and the latency are
// returned on the response port. Only one command is in flight at a time.
//
// Ports:
//   clk        rising-edge clock
//   reset      synchronous, active-high
//   bus        pcpi_issuer_if.master (command, PCPI, response, proto_err)
//   state_dbg  current FSM state (0 IDLE, 1 ISSUE, 2 RESP)
module pcpi_issuer #(
  parameter int XLEN    = 32,
  parameter int TIMEOUT = 16,
  parameter int CYC_W   = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  pcpi_issuer_if.master        bus,
  output logic [1:0]           state_dbg
);

  localparam int TW = $clog2(TIMEOUT);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic             pcpi_valid_q, pcpi_valid_d;
  logic [XLEN-1:0]  insn_q, insn_d;
  logic [XLEN-1:0]  rs1_q, rs1_d;
  logic [XLEN-1:0]  rs2_q, rs2_d;
  logic [TW-1:0]    timer_q, timer_d;
  logic [CYC_W-1:0] cyc_q, cyc_d;
  logic [XLEN-1:0]  rsp_rd_q, rsp_rd_d;
  logic             rsp_wr_q, rsp_wr_d;
  logic             rsp_timeout_q, rsp_timeout_d;
  logic [CYC_W-1:0] rsp_cycles_q, rsp_cycles_d;
  logic             proto_err_q, proto_err_d;

  // Latency counter value including the current cycle; sticks at all-ones.
  logic [CYC_W-1:0] cyc_inc;
  assign cyc_inc = (cyc_q == {CYC_W{1'b1}}) ? cyc_q : cyc_q + {{(CYC_W-1){1'b0}}, 1'b1};

  always_comb begin
    state_d       = state_q;
    pcpi_valid_d  = pcpi_valid_q;
    insn_d        = insn_q;
    rs1_d         = rs1_q;
    rs2_d         = rs2_q;
    timer_d       = timer_q;
    cyc_d         = cyc_q;
    rsp_rd_d      = rsp_rd_q;
    rsp_wr_d      = rsp_wr_q;
    rsp_timeout_d = rsp_timeout_q;
    rsp_cycles_d  = rsp_cycles_q;
    // A ready from the coprocessor with nothing issued is a protocol error.
    // Its rd/wr are otherwise ignored.
    proto_err_d   = proto_err_q | (bus.pcpi_ready & ~pcpi_valid_q);

    case (state_q)
      IDLE: begin
        if (bus.cmd_valid) begin
          insn_d       = bus.cmd_insn;
          rs1_d        = bus.cmd_rs1;
          rs2_d        = bus.cmd_rs2;
          pcpi_valid_d = 1'b1;
          timer_d      = '0;
          cyc_d        = '0;
          state_d      = ISSUE;
        end
      end
      ISSUE: begin
        cyc_d = cyc_inc;
        if (bus.pcpi_ready) begin
          // Completion beats a timeout that would fire in the same cycle.
          rsp_rd_d      = bus.pcpi_rd;
          rsp_wr_d      = bus.pcpi_wr;
          rsp_timeout_d = 1'b0;
          rsp_cycles_d  = cyc_inc;
          pcpi_valid_d  = 1'b0;
          state_d       = RESP;
        end else if (bus.pcpi_wait) begin
          timer_d = '0;
        end else if (timer_q == TW'(TIMEOUT - 1)) begin
          // The timer reads k-1 in the k-th consecutive silent cycle, so this
          // abort happens on the TIMEOUT-th such cycle.
          rsp_rd_d      = '0;
          rsp_wr_d      = 1'b0;
          rsp_timeout_d = 1'b1;
          rsp_cycles_d  = cyc_inc;
          pcpi_valid_d  = 1'b0;
          state_d       = RESP;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      RESP: begin
        if (bus.rsp_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d      = IDLE;
        pcpi_valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= IDLE;
      pcpi_valid_q  <= 1'b0;
      insn_q        <= '0;
      rs1_q         <= '0;
      rs2_q         <= '0;
      timer_q       <= '0;
      cyc_q         <= '0;
      rsp_rd_q      <= '0;
      rsp_wr_q      <= 1'b0;
      rsp_timeout_q <= 1'b0;
      rsp_cycles_q  <= '0;
      proto_err_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      pcpi_valid_q  <= pcpi_valid_d;
      insn_q        <= insn_d;
      rs1_q         <= rs1_d;
      rs2_q         <= rs2_d;
      timer_q       <= timer_d;
      cyc_q         <= cyc_d;
      rsp_rd_q      <= rsp_rd_d;
      rsp_wr_q      <= rsp_wr_d;
      rsp_timeout_q <= rsp_timeout_d;
      rsp_cycles_q  <= rsp_cycles_d;
      proto_err_q   <= proto_err_d;
    end
  end

  // cmd_ready is low while reset is asserted and high in the first cycle
  // after it, because the state register is already IDLE by then.
  assign bus.cmd_ready   = (state_q == IDLE) && !reset;
  assign bus.pcpi_valid  = pcpi_valid_q;
  assign bus.pcpi_insn   = insn_q;
  assign bus.pcpi_rs1    = rs1_q;
  assign bus.pcpi_rs2    = rs2_q;
  assign bus.rsp_valid   = (state_q == RESP);
  assign bus.rsp_rd      = rsp_rd_q;
  assign bus.rsp_wr      = rsp_wr_q;
  assign bus.rsp_timeout = rsp_timeout_q;
  assign bus.rsp_cycles  = rsp_cycles_q;
  assign bus.proto_err   = proto_err_q;
  assign state_dbg       = state_q;

endmodule

// File: tb/tb_pcpi_issuer.sv
module tb_pcpi_issuer;

  localparam int XLEN    = 32;
  localparam int TIMEOUT = 16;
  localparam int CYC_W   = 16;

  // ---------------- clock / reset ----------------
  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [1:0] state_dbg;

  always #5 clk = ~clk;

  pcpi_issuer_if #(.XLEN(XLEN), .CYC_W(CYC_W)) bus ();

  pcpi_issuer #(.XLEN(XLEN), .TIMEOUT(TIMEOUT), .CYC_W(CYC_W)) dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus),
    .state_dbg (state_dbg)
  );

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Tracks the transaction: whether an instruction is outstanding, how long it
  // has been presented, how many silent cycles in a row have passed, and
  // whether a response is waiting to be taken.
  logic            m_busy = 1'b0;
  logic            m_rsp_pend = 1'b0;
  logic [XLEN-1:0] m_insn = '0, m_rs1 = '0, m_rs2 = '0;
  logic [XLEN-1:0] m_rd = '0;
  logic            m_wr = 1'b0, m_to = 1'b0, m_proto = 1'b0;
  int              m_high = 0;
  int              m_silent = 0;
  int              m_cyc = 0;

  initial begin
    forever begin
      @(posedge clk);
      if (reset) begin
        m_busy = 0; m_rsp_pend = 0; m_insn = '0; m_rs1 = '0; m_rs2 = '0;
        m_rd = '0; m_wr = 0; m_to = 0; m_proto = 0; m_cyc = 0;
      end else begin
        if (bus.pcpi_ready && !m_busy) m_proto = 1;
        if (m_rsp_pend) begin
          if (bus.rsp_ready) m_rsp_pend = 0;
        end else if (m_busy) begin
          m_high++;
          if (bus.pcpi_ready) begin
            m_rd = bus.pcpi_rd; m_wr = bus.pcpi_wr; m_to = 0;
            m_cyc = (m_high > 65535) ? 65535 : m_high;
            m_busy = 0; m_rsp_pend = 1;
          end else if (bus.pcpi_wait) begin
            m_silent = 0;
          end else begin
            m_silent++;
            if (m_silent == TIMEOUT) begin
              m_rd = '0; m_wr = 0; m_to = 1;
              m_cyc = (m_high > 65535) ? 65535 : m_high;
              m_busy = 0; m_rsp_pend = 1;
            end
          end
        end else if (bus.cmd_valid) begin
          m_insn = bus.cmd_insn; m_rs1 = bus.cmd_rs1; m_rs2 = bus.cmd_rs2;
          m_busy = 1; m_high = 0; m_silent = 0;
        end
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  initial begin
    @(posedge clk);
    forever begin
      @(negedge clk);
      chk("cmd_ready",   64'(bus.cmd_ready),   64'(!reset && !m_busy && !m_rsp_pend));
      chk("pcpi_valid",  64'(bus.pcpi_valid),  64'(m_busy));
      chk("pcpi_insn",   64'(bus.pcpi_insn),   64'(m_insn));
      chk("pcpi_rs1",    64'(bus.pcpi_rs1),    64'(m_rs1));
      chk("pcpi_rs2",    64'(bus.pcpi_rs2),    64'(m_rs2));
      chk("rsp_valid",   64'(bus.rsp_valid),   64'(m_rsp_pend));
      chk("rsp_rd",      64'(bus.rsp_rd),      64'(m_rd));
      chk("rsp_wr",      64'(bus.rsp_wr),      64'(m_wr));
      chk("rsp_timeout", 64'(bus.rsp_timeout), 64'(m_to));
      chk("rsp_cycles",  64'(bus.rsp_cycles),  64'(m_cyc));
      chk("proto_err",   64'(bus.proto_err),   64'(m_proto));
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_cmd(input logic [31:0] insn, input logic [31:0] rs1, input logic [31:0] rs2);
    int n = 0;
    bus.cmd_valid = 1'b1;
    bus.cmd_insn  = insn;
    bus.cmd_rs1   = rs1;
    bus.cmd_rs2   = rs2;
    while (!bus.cmd_ready && n < 50) begin
      tick();
      n++;
    end
    chk("cmd_accept_bound", 64'(n < 50), 64'd1);
    tick();
    bus.cmd_valid = 1'b0;
  endtask

  task automatic respond(input int waits, input int silent, input logic [31:0] rd, input logic wr);
    for (int i = 0; i < waits; i++) begin
      bus.pcpi_wait = 1'b1;
      tick();
    end
    bus.pcpi_wait = 1'b0;
    for (int i = 0; i < silent; i++) tick();
    bus.pcpi_ready = 1'b1;
    bus.pcpi_rd    = rd;
    bus.pcpi_wr    = wr;
    tick();
    bus.pcpi_ready = 1'b0;
    bus.pcpi_rd    = '0;
    bus.pcpi_wr    = 1'b0;
  endtask

  task automatic get_rsp(output logic [31:0] rd, output logic wr, output logic to,
                         output logic [15:0] cyc);
    int n = 0;
    while (!bus.rsp_valid && n < 100) begin
      tick();
      n++;
    end
    chk("rsp_valid_bound", 64'(n < 100), 64'd1);
    rd  = bus.rsp_rd;
    wr  = bus.rsp_wr;
    to  = bus.rsp_timeout;
    cyc = bus.rsp_cycles;
    bus.rsp_ready = 1'b1;
    tick();
    bus.rsp_ready = 1'b0;
  endtask

  // ---------------- directed tests ----------------
  logic [31:0] r_rd;
  logic        r_wr, r_to;
  logic [15:0] r_cyc;
  int          high_cnt;

  initial begin
    bus.cmd_valid = 0; bus.cmd_insn = '0; bus.cmd_rs1 = '0; bus.cmd_rs2 = '0;
    bus.pcpi_wr = 0; bus.pcpi_rd = '0; bus.pcpi_wait = 0; bus.pcpi_ready = 0;
    bus.rsp_ready = 0;
    tick(); tick(); tick();
    chk("reset_cmd_ready", 64'(bus.cmd_ready), 64'd0);
    chk("reset_pcpi_valid", 64'(bus.pcpi_valid), 64'd0);
    reset = 1'b0;
    tick();
    chk("post_reset_cmd_ready", 64'(bus.cmd_ready), 64'd1);

    // 1: three wait cycles, then ready with a result
    send_cmd(32'h0020_8053, 32'h3F80_0000, 32'h4000_0000);
    chk("t1_pcpi_insn", 64'(bus.pcpi_insn), 64'h0020_8053);
    respond(3, 0, 32'h4040_0000, 1'b1);
    get_rsp(r_rd, r_wr, r_to, r_cyc);
    chk("t1_rd", 64'(r_rd), 64'h4040_0000);
    chk("t1_wr", 64'(r_wr), 64'd1);
    chk("t1_to", 64'(r_to), 64'd0);
    chk("t1_cyc", 64'(r_cyc), 64'd4);

    // 2: coprocessor never answers
    bus.pcpi_rd = 32'hDEAD_BEEF;
    send_cmd(32'h1234_5678, 32'h1, 32'h2);
    high_cnt = 0;
    while (bus.pcpi_valid && high_cnt < 100) begin
      high_cnt++;
      tick();
    end
    chk("t2_high_cycles", 64'(high_cnt), 64'd16);
    bus.pcpi_rd = '0;
    get_rsp(r_rd, r_wr, r_to, r_cyc);
    chk("t2_to", 64'(r_to), 64'd1);
    chk("t2_rd", 64'(r_rd), 64'd0);
    chk("t2_wr", 64'(r_wr), 64'd0);
    chk("t2_cyc", 64'(r_cyc), 64'd16);

    // 3: long busy period keeps the timeout away
    send_cmd(32'hAAAA_0001, 32'h5, 32'h6);
    respond(100, 0, 32'h0000_00AB, 1'b1);
    get_rsp(r_rd, r_wr, r_to, r_cyc);
    chk("t3_to", 64'(r_to), 64'd0);
    chk("t3_cyc", 64'(r_cyc), 64'd101);
    chk("t3_rd", 64'(r_rd), 64'h0000_00AB);

    // 4: ready lands on the 16th silent cycle, exactly when the abort would fire
    send_cmd(32'hBBBB_0002, 32'h7, 32'h8);
    respond(0, TIMEOUT - 1, 32'h0BAD_F00D, 1'b0);
    get_rsp(r_rd, r_wr, r_to, r_cyc);
    chk("t4_to", 64'(r_to), 64'd0);
    chk("t4_rd", 64'(r_rd), 64'h0BAD_F00D);
    chk("t4_wr", 64'(r_wr), 64'd0);
    chk("t4_cyc", 64'(r_cyc), 64'd16);

    // 5: consumer stalls the response; a waiting command must not be accepted
    send_cmd(32'hCCCC_0003, 32'h9, 32'hA);
    respond(0, 0, 32'h5555_AAAA, 1'b1);
    bus.cmd_valid = 1'b1;
    bus.cmd_insn  = 32'hEEEE_0004;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("t5_cmd_ready", 64'(bus.cmd_ready), 64'd0);
      chk("t5_no_accept", 64'(bus.pcpi_valid), 64'd0);
      chk("t5_rsp_rd", 64'(bus.rsp_rd), 64'h5555_AAAA);
      chk("t5_rsp_valid", 64'(bus.rsp_valid), 64'd1);
    end
    bus.cmd_valid = 1'b0;
    get_rsp(r_rd, r_wr, r_to, r_cyc);
    chk("t5_cyc", 64'(r_cyc), 64'd1);
    chk("t5_insn_kept", 64'(bus.pcpi_insn), 64'hCCCC_0003);

    // 6: stray ready while idle, then reset in the middle of an issue
    tick();
    chk("t6_proto_before", 64'(bus.proto_err), 64'd0);
    bus.pcpi_ready = 1'b1; bus.pcpi_wr = 1'b1; bus.pcpi_rd = 32'h0000_0123;
    tick();
    bus.pcpi_ready = 1'b0; bus.pcpi_wr = 1'b0; bus.pcpi_rd = '0;
    chk("t6_proto_set", 64'(bus.proto_err), 64'd1);
    chk("t6_no_rsp", 64'(bus.rsp_valid), 64'd0);
    tick(); tick(); tick();
    chk("t6_proto_sticky", 64'(bus.proto_err), 64'd1);
    send_cmd(32'hDDDD_0005, 32'hB, 32'hC);
    tick();
    reset = 1'b1;
    tick();
    chk("t6_valid_after_reset", 64'(bus.pcpi_valid), 64'd0);
    chk("t6_proto_cleared", 64'(bus.proto_err), 64'd0);
    reset = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      chk("t6_no_rsp_after_reset", 64'(bus.rsp_valid), 64'd0);
    end

    tick(); tick();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Watchdog for the whole run.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

endmodule
